// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding I-cache request at a time, a table
// of 2-bit branch counters for next-pc prediction, and an in-order issue queue.
module inst_fetch_queue #(
    parameter int PRED_IDX_W = 8,
    parameter int IQ_DEPTH_W = 2,
    parameter int JAL_PRED   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        pc_send_enable,
    output logic [31:0] pc_to_ic,
    input  logic        inst_get_ready,
    input  logic [31:0] inst_from_ic,
    output logic        inst_send_enable,
    output logic [31:0] inst_to_issue,
    output logic [31:0] pc_to_issue,
    output logic        pred_to_issue,
    input  logic        issue_stall,
    input  logic        jump_flag,
    input  logic [31:0] target_pc,
    input  logic        upd_pred_valid,
    input  logic [31:0] upd_pred_pc,
    input  logic        upd_pred_need_jump
);
    localparam int PRED_N = 2 ** PRED_IDX_W;
    localparam int IQ_DEPTH = 2 ** IQ_DEPTH_W;
    localparam logic [IQ_DEPTH_W:0]   FULL_CNT = (IQ_DEPTH_W + 1)'(IQ_DEPTH);
    localparam logic [IQ_DEPTH_W:0]   CNT_ONE  = (IQ_DEPTH_W + 1)'(1);
    localparam logic [IQ_DEPTH_W-1:0] PTR_ONE  = IQ_DEPTH_W'(1);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} fetch_state_e;

    fetch_state_e          state_r, state_nxt_s;
    logic                  req_nxt_s, issue_req_s, push_s, pop_s, flush_s;
    logic [31:0]           pc_r, next_pc_s;
    logic                  pred_s;
    logic [1:0]            lookup_ctr_s, upd_ctr_s;
    logic [PRED_IDX_W-1:0] upd_idx_s;
    logic [IQ_DEPTH_W-1:0] head_r, tail_r;
    logic [IQ_DEPTH_W:0]   count_r;
    logic [31:0]           iq_inst_r [IQ_DEPTH];
    logic [31:0]           iq_pc_r   [IQ_DEPTH];
    logic                  iq_pred_r [IQ_DEPTH];
    logic [1:0]            bht_r     [PRED_N];
    logic                  unused_upd_pc_bits_s;

    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    assign upd_idx_s = upd_pred_pc[PRED_IDX_W+1:2];
    assign upd_ctr_s = bht_r[upd_idx_s];
    assign unused_upd_pc_bits_s = ^{upd_pred_pc[31:PRED_IDX_W+2], upd_pred_pc[1:0]};

    // Fetch FSM next state and queue push/pop decisions; flush outranks a stalled core.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = pc_send_enable;
        issue_req_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        flush_s     = 1'b0;
        if (rst) begin
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
        end else if (jump_flag) begin
            flush_s     = 1'b1;
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
        end else if (!rdy) begin
            state_nxt_s = IDLE;
            req_nxt_s   = 1'b0;
        end else begin
            pop_s = (count_r != '0) && !issue_stall;
            case (state_r)
                IDLE: begin
                    if (count_r != FULL_CNT) begin
                        issue_req_s = 1'b1;
                        req_nxt_s   = 1'b1;
                        state_nxt_s = WAIT;
                    end else begin
                        req_nxt_s = 1'b0;
                    end
                end
                WAIT: begin
                    if (inst_get_ready) begin
                        push_s      = 1'b1;
                        req_nxt_s   = 1'b0;
                        state_nxt_s = IDLE;
                    end else begin
                        req_nxt_s = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    req_nxt_s   = 1'b0;
                end
            endcase
        end
    end

    // Predict the successor of the returning word using the pre-update counter.
    always_comb begin
        lookup_ctr_s = bht_r[pc_r[PRED_IDX_W+1:2]];
        if ((inst_from_ic[6:0] == OP_BRANCH) && lookup_ctr_s[1]) begin
            pred_s    = 1'b1;
            next_pc_s = pc_r + b_imm(inst_from_ic);
        end else if ((inst_from_ic[6:0] == OP_JAL) && (JAL_PRED != 0)) begin
            pred_s    = 1'b1;
            next_pc_s = pc_r + j_imm(inst_from_ic);
        end else begin
            pred_s    = 1'b0;
            next_pc_s = pc_r + 32'd4;
        end
    end

    // FSM state and I-cache request strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            pc_send_enable <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            pc_send_enable <= req_nxt_s;
        end
    end

    // Fetch pc and the latched request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= 32'd0;
            pc_to_ic <= 32'd0;
        end else begin
            if (flush_s) begin
                pc_r <= target_pc;
            end else if (push_s) begin
                pc_r <= next_pc_s;
            end
            if (issue_req_s) begin
                pc_to_ic <= pc_r;
            end
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at IQ_DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_s) tail_r <= tail_r + PTR_ONE;
            if (pop_s)  head_r <= head_r + PTR_ONE;
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Queue payload storage.
    always_ff @(posedge clk) begin
        if (push_s) begin
            iq_inst_r[tail_r] <= inst_from_ic;
            iq_pc_r[tail_r]   <= pc_r;
            iq_pred_r[tail_r] <= pred_s;
        end
    end

    // Registered issue port, one strobe per popped entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_send_enable <= 1'b0;
            inst_to_issue    <= 32'd0;
            pc_to_issue      <= 32'd0;
            pred_to_issue    <= 1'b0;
        end else if (pop_s) begin
            inst_send_enable <= 1'b1;
            inst_to_issue    <= iq_inst_r[head_r];
            pc_to_issue      <= iq_pc_r[head_r];
            pred_to_issue    <= iq_pred_r[head_r];
        end else begin
            inst_send_enable <= 1'b0;
        end
    end

    // Saturating 2-bit counters; training survives a flush but not a stalled core.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PRED_N; i++) bht_r[i] <= 2'b01;
        end else if (upd_pred_valid && (rdy || jump_flag)) begin
            if (upd_pred_need_jump) begin
                if (upd_ctr_s != 2'b11) bht_r[upd_idx_s] <= upd_ctr_s + 2'd1;
            end else begin
                if (upd_ctr_s != 2'b00) bht_r[upd_idx_s] <= upd_ctr_s - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: I-cache model, fetch-pc and counter reference model,
// issue scoreboard, a counter training vector table and hand-built corner sequences.
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1, rdy = 1'b1;
    logic        pc_send_enable, inst_send_enable, pred_to_issue;
    logic [31:0] pc_to_ic, inst_to_issue, pc_to_issue;
    logic        inst_get_ready = 1'b0, issue_stall = 1'b0, jump_flag = 1'b0;
    logic        upd_pred_valid = 1'b0, upd_pred_need_jump = 1'b0;
    logic [31:0] inst_from_ic = 32'd0, target_pc = 32'd0, upd_pred_pc = 32'd0;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_send_enable(pc_send_enable), .pc_to_ic(pc_to_ic),
        .inst_get_ready(inst_get_ready), .inst_from_ic(inst_from_ic),
        .inst_send_enable(inst_send_enable), .inst_to_issue(inst_to_issue),
        .pc_to_issue(pc_to_issue), .pred_to_issue(pred_to_issue),
        .issue_stall(issue_stall), .jump_flag(jump_flag), .target_pc(target_pc),
        .upd_pred_valid(upd_pred_valid), .upd_pred_pc(upd_pred_pc),
        .upd_pred_need_jump(upd_pred_need_jump)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    typedef struct {
        logic take;
        logic exp_pred;
    } vec_t;

    entry_t      sb[$];
    entry_t      iss_log[$];
    logic [31:0] req_log[$];
    logic [31:0] mem [logic [31:0]];
    logic [1:0]  cnt_m [256];
    logic [31:0] m_pc;
    logic        prev_pse;
    bit          rst_req = 1'b1, rdy_req = 1'b1, stall_req = 1'b0, hit_en = 1'b0;
    bit          jump_req = 1'b0, upd_req = 1'b0, upd_take = 1'b0;
    logic [31:0] jump_tgt = 32'd0, upd_addr = 32'd0;
    int          n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0000_0013;
    endfunction

    function automatic logic m_pred(input logic [31:0] ins, input logic [1:0] ctr);
        if (ins[6:0] == 7'b1100011) return (ctr >= 2'b10);
        if (ins[6:0] == 7'b1101111) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] ins, input logic [31:0] pc, input logic p);
        if (!p) return pc + 32'd4;
        if (ins[6:0] == 7'b1100011)
            return pc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        return pc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic entry_t iss_at(input int i);
        if (i < iss_log.size()) return iss_log[i];
        return '1;
    endfunction

    // One clock: observe outputs at negedge, drive inputs, advance the models.
    task automatic cycle();
        entry_t e, x;
        logic   p;
        @(negedge clk);
        if (!rst) begin
            if (pc_send_enable && !prev_pse) begin
                req_log.push_back(pc_to_ic);
                check("req_addr", pc_to_ic, m_pc);
            end
            if (inst_send_enable) begin
                e = '{inst_to_issue, pc_to_issue, pred_to_issue};
                iss_log.push_back(e);
                if (sb.size() == 0) begin
                    check("strobe_no_entry", {31'd0, inst_send_enable}, 32'd0);
                end else begin
                    x = sb.pop_front();
                    check("issue_inst", inst_to_issue, x.inst);
                    check("issue_pc", pc_to_issue, x.pc);
                    check("issue_pred", {31'd0, pred_to_issue}, {31'd0, x.pred});
                end
            end
        end
        prev_pse           = pc_send_enable;
        rst                = rst_req;
        rdy                = rdy_req;
        issue_stall        = stall_req;
        jump_flag          = jump_req;
        target_pc          = jump_tgt;
        upd_pred_valid     = upd_req;
        upd_pred_pc        = upd_addr;
        upd_pred_need_jump = upd_take;
        inst_get_ready     = hit_en && pc_send_enable;
        inst_from_ic       = fetch_word(m_pc);
        if (!rst) begin
            if (jump_flag) begin
                sb.delete();
                m_pc = target_pc;
            end else if (rdy && inst_get_ready) begin
                p = m_pred(inst_from_ic, cnt_m[m_pc[9:2]]);
                sb.push_back('{inst_from_ic, m_pc, p});
                m_pc = m_next(inst_from_ic, m_pc, p);
            end
            if (upd_pred_valid && (rdy || jump_flag)) begin
                if (upd_take && cnt_m[upd_addr[9:2]] != 2'b11)
                    cnt_m[upd_addr[9:2]] = cnt_m[upd_addr[9:2]] + 2'd1;
                else if (!upd_take && cnt_m[upd_addr[9:2]] != 2'b00)
                    cnt_m[upd_addr[9:2]] = cnt_m[upd_addr[9:2]] - 2'd1;
            end
        end
        jump_req = 1'b0;
        upd_req  = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        rst_req = 1'b1; rdy_req = 1'b1; stall_req = 1'b0; hit_en = 1'b0;
        cycle();
        cycle();
        #1;
        check("rst_pc_send_enable", {31'd0, pc_send_enable}, 32'd0);
        check("rst_pc_to_ic", pc_to_ic, 32'd0);
        check("rst_inst_send_enable", {31'd0, inst_send_enable}, 32'd0);
        check("rst_inst_to_issue", inst_to_issue, 32'd0);
        check("rst_pc_to_issue", pc_to_issue, 32'd0);
        check("rst_pred_to_issue", {31'd0, pred_to_issue}, 32'd0);
        m_pc = 32'd0;
        sb.delete(); req_log.delete(); iss_log.delete();
        for (int i = 0; i < 256; i++) cnt_m[i] = 2'b01;
        prev_pse = 1'b0;
        rst_req  = 1'b0;
    endtask

    initial begin
        vec_t   tbl[12];
        entry_t t;
        bit     found;
        tbl[0]  = '{1'b1, 1'b1}; tbl[1]  = '{1'b1, 1'b1}; tbl[2]  = '{1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1}; tbl[4]  = '{1'b1, 1'b1}; tbl[5]  = '{1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0}; tbl[7]  = '{1'b0, 1'b0}; tbl[8]  = '{1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0}; tbl[10] = '{1'b1, 1'b0}; tbl[11] = '{1'b1, 1'b1};
        mem[32'h10]  = 32'hFE00_0EE3;
        mem[32'h40]  = 32'hFE00_0EE3;
        mem[32'h104] = 32'h0200_006F;

        // Sequential fetch with a short rdy drop
        do_reset();
        hit_en = 1'b1;
        repeat (8) cycle();
        rdy_req = 1'b0;
        cycle();
        #1;
        check("rdy0_pc_send_enable", {31'd0, pc_send_enable}, 32'd0);
        check("rdy0_inst_send_enable", {31'd0, inst_send_enable}, 32'd0);
        cycle(); cycle();
        rdy_req = 1'b1;
        repeat (8) cycle();
        for (int i = 0; i < 3; i++) begin
            check("seq_req", req_at(i), 32'(i * 4));
            t = iss_at(i);
            check("seq_issue_pc", t.pc, 32'(i * 4));
            check("seq_issue_pred", {31'd0, t.pred}, 32'd0);
        end

        // Trained backward BEQ at 0x10
        do_reset();
        upd_req = 1'b1; upd_take = 1'b1; upd_addr = 32'h10; cycle();
        upd_req = 1'b1; upd_take = 1'b1; upd_addr = 32'h10; cycle();
        hit_en = 1'b1;
        repeat (20) cycle();
        check("beq_req4", req_at(4), 32'h10);
        check("beq_req5", req_at(5), 32'h0C);
        t = iss_at(4);
        check("beq_issue_pc", t.pc, 32'h10);
        check("beq_issue_pred", {31'd0, t.pred}, 32'd1);

        // Queue fills under stall, then drains in order
        do_reset();
        stall_req = 1'b1; hit_en = 1'b1;
        repeat (20) cycle();
        #1;
        check("full_push_count", 32'(req_log.size()), 32'd4);
        check("full_pc_send_enable", {31'd0, pc_send_enable}, 32'd0);
        check("full_inst_send_enable", {31'd0, inst_send_enable}, 32'd0);
        stall_req = 1'b0;
        repeat (12) cycle();
        for (int i = 0; i < 4; i++) begin
            t = iss_at(i);
            check("drain_pc", t.pc, 32'(i * 4));
        end

        // Flush colliding with an I-cache return, two entries queued
        do_reset();
        stall_req = 1'b1; hit_en = 1'b1;
        for (int k = 0; k < 20 && sb.size() < 2; k++) cycle();
        check("flush_setup_entries", 32'(sb.size()), 32'd2);
        hit_en = 1'b0;
        cycle(); cycle();
        #1;
        check("flush_setup_pending", {31'd0, pc_send_enable}, 32'd1);
        hit_en = 1'b1; stall_req = 1'b0; jump_req = 1'b1; jump_tgt = 32'h100;
        cycle();
        req_log.delete(); iss_log.delete();
        repeat (14) cycle();
        check("flush_req0", req_at(0), 32'h100);
        check("flush_req1", req_at(1), 32'h104);
        check("flush_req2", req_at(2), 32'h124);
        t = iss_at(0);
        check("flush_first_issue", t.pc, 32'h100);
        t = iss_at(1);
        check("jal_issue_pred", {31'd0, t.pred}, 32'd1);

        // Counter saturation: one update, then a redirected probe fetch of 0x40
        do_reset();
        hit_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            upd_req = 1'b1; upd_take = tbl[i].take; upd_addr = 32'h40;
            cycle();
            jump_req = 1'b1; jump_tgt = 32'h40;
            cycle();
            iss_log.delete();
            found = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                cycle();
                if (iss_log.size() > 0) begin
                    found = 1'b1;
                    check("ctr_probe_pc", iss_log[0].pc, 32'h40);
                    check("ctr_probe_pred", {31'd0, iss_log[0].pred}, {31'd0, tbl[i].exp_pred});
                end
            end
            if (!found) check("ctr_probe_timeout", 32'd0, 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
